// File: rtl/imm_pkg.sv
// Shared immediate-format definitions: format codes, placement masks and the
// field placement used by the immediate encoder (and its extender counterpart).
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100
    } immsrc_t;

    localparam int FIELD_W = 25;

    localparam logic [FIELD_W-1:0] MASK_I = 25'h1FFE000;
    localparam logic [FIELD_W-1:0] MASK_S = 25'h1FC001F;
    localparam logic [FIELD_W-1:0] MASK_B = 25'h1FC001F;
    localparam logic [FIELD_W-1:0] MASK_U = 25'h1FFFFE0;
    localparam logic [FIELD_W-1:0] MASK_J = 25'h1FFFFE0;

    // Field bit k lands on instruction bit k+7.
    function automatic logic [FIELD_W-1:0] place_field(input logic [31:0] imm,
                                                       input logic [2:0]  src);
        logic [FIELD_W-1:0] f;
        f = '0;
        case (src)
            IMM_I: f[24:13] = imm[11:0];
            IMM_S: begin
                f[24:18] = imm[11:5];
                f[4:0]   = imm[4:0];
            end
            IMM_B: begin
                f[24]    = imm[12];
                f[23:18] = imm[10:5];
                f[4:1]   = imm[4:1];
                f[0]     = imm[11];
            end
            IMM_U: f[24:5] = imm[31:12];
            IMM_J: begin
                f[24]    = imm[20];
                f[23:14] = imm[10:1];
                f[13]    = imm[11];
                f[12:5]  = imm[19:12];
            end
            default: f = '0;
        endcase
        return f;
    endfunction

    function automatic logic [FIELD_W-1:0] format_mask(input logic [2:0] src);
        logic [FIELD_W-1:0] m;
        case (src)
            IMM_I:   m = MASK_I;
            IMM_S:   m = MASK_S;
            IMM_B:   m = MASK_B;
            IMM_U:   m = MASK_U;
            IMM_J:   m = MASK_J;
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/imm_range_check.sv
// Combinational representability check: flags immediates the selected format
// cannot encode, and all illegal format codes.
module imm_range_check
    import imm_pkg::*;
(
    input  logic [31:0] imm_i,
    input  logic [2:0]  immsrc_i,
    output logic        err_o
);

    logic sext12_ok;
    logic sext13_ok;
    logic sext21_ok;

    // A field of N signed bits holds the value iff every bit above N-1 equals the sign.
    assign sext12_ok = (&imm_i[31:11]) || !(|imm_i[31:11]);
    assign sext13_ok = (&imm_i[31:12]) || !(|imm_i[31:12]);
    assign sext21_ok = (&imm_i[31:20]) || !(|imm_i[31:20]);

    always_comb begin
        err_o = 1'b1;
        case (immsrc_i)
            IMM_I, IMM_S: err_o = !sext12_ok;
            IMM_B:        err_o = !sext13_ok || imm_i[0];
            IMM_U:        err_o = |imm_i[11:0];
            IMM_J:        err_o = !sext21_ok || imm_i[0];
            default:      err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage pipelined immediate encoder: S1 registers the request and its range
// verdict, S2 registers the placed field, mask and error flag.
module imm_encoder
    import imm_pkg::*;
#(
    parameter logic [FIELD_W-1:0] RST_VAL = '0,
    parameter int                 CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_imm,
    input  logic [2:0]         in_immsrc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FIELD_W-1:0] out_field,
    output logic [FIELD_W-1:0] out_mask,
    output logic               out_err,
    output logic [CNT_W-1:0]   err_cnt
);

    logic               adv;
    logic               in_err;

    logic               s1_valid_q, s1_valid_d;
    logic [31:0]        s1_imm_q,   s1_imm_d;
    logic [2:0]         s1_src_q,   s1_src_d;
    logic               s1_err_q,   s1_err_d;

    logic               s2_valid_q, s2_valid_d;
    logic [FIELD_W-1:0] s2_field_q, s2_field_d;
    logic [FIELD_W-1:0] s2_mask_q,  s2_mask_d;
    logic               s2_err_q,   s2_err_d;

    logic [CNT_W-1:0]   err_cnt_q,  err_cnt_d;

    imm_range_check u_range_check (
        .imm_i    (in_imm),
        .immsrc_i (in_immsrc),
        .err_o    (in_err)
    );

    // Whole pipe moves together; an empty or draining output slot frees it.
    assign adv      = !s2_valid_q || out_ready;
    assign in_ready = adv;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_imm_d   = s1_imm_q;
        s1_src_d   = s1_src_q;
        s1_err_d   = s1_err_q;
        s2_valid_d = s2_valid_q;
        s2_field_d = s2_field_q;
        s2_mask_d  = s2_mask_q;
        s2_err_d   = s2_err_q;
        err_cnt_d  = err_cnt_q;

        if (adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_imm_d = in_imm;
                s1_src_d = in_immsrc;
                s1_err_d = in_err;
            end
            s2_valid_d = s1_valid_q;
            // Bubbles leave the data registers untouched so RST_VAL persists until the first result.
            if (s1_valid_q) begin
                s2_err_d   = s1_err_q;
                s2_field_d = s1_err_q ? '0 : place_field(s1_imm_q, s1_src_q);
                s2_mask_d  = s1_err_q ? '0 : format_mask(s1_src_q);
            end
        end

        if (s2_valid_q && out_ready && s2_err_q && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_imm_q   <= '0;
            s1_src_q   <= '0;
            s1_err_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_field_q <= RST_VAL;
            s2_mask_q  <= RST_VAL;
            s2_err_q   <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_imm_q   <= s1_imm_d;
            s1_src_q   <= s1_src_d;
            s1_err_q   <= s1_err_d;
            s2_valid_q <= s2_valid_d;
            s2_field_q <= s2_field_d;
            s2_mask_q  <= s2_mask_d;
            s2_err_q   <= s2_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_field = s2_field_q;
    assign out_mask  = s2_mask_q;
    assign out_err   = s2_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: a driver pushes expected results from an
// arithmetic reference model, an independent monitor pops and compares them.
module tb_imm_encoder;

    localparam int CNT_W = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       in_imm = '0;
    logic [2:0]        in_immsrc = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [24:0]       out_field;
    logic [24:0]       out_mask;
    logic              out_err;
    logic [CNT_W-1:0]  err_cnt;

    imm_encoder #(.RST_VAL(25'h0), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_immsrc (in_immsrc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_field (out_field),
        .out_mask  (out_mask),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [24:0] field;
        logic [24:0] mask;
        logic        err;
        logic        chk_lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic stall = 1'b0;
    logic rand_rdy = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            failures = failures + 1;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // Reference: ranges as signed integer bounds, placement by shift-and-mask arithmetic.
    function automatic exp_t model(input logic [31:0] imm, input logic [2:0] src);
        exp_t        e;
        int          v;
        logic        ok;
        logic [31:0] f;
        logic [24:0] m;
        v = int'(imm);
        ok = 1'b0;
        f = 32'h0;
        m = 25'h0;
        case (src)
            3'd0: begin
                ok = (v >= -2048) && (v <= 2047);
                f = (imm & 32'hFFF) << 13;
                m = 25'h1FFE000;
            end
            3'd1: begin
                ok = (v >= -2048) && (v <= 2047);
                f = (((imm >> 5) & 32'h7F) << 18) | (imm & 32'h1F);
                m = 25'h1FC001F;
            end
            3'd2: begin
                ok = (v >= -4096) && (v <= 4095) && ((imm & 32'h1) == 0);
                f = (((imm >> 12) & 32'h1) << 24) | (((imm >> 5) & 32'h3F) << 18) |
                    (((imm >> 1) & 32'hF) << 1) | ((imm >> 11) & 32'h1);
                m = 25'h1FC001F;
            end
            3'd3: begin
                ok = (imm & 32'hFFF) == 0;
                f = (imm >> 12) << 5;
                m = 25'h1FFFFE0;
            end
            3'd4: begin
                ok = (v >= -(1 << 20)) && (v < (1 << 20)) && ((imm & 32'h1) == 0);
                f = (((imm >> 20) & 32'h1) << 24) | (((imm >> 1) & 32'h3FF) << 14) |
                    (((imm >> 11) & 32'h1) << 13) | (((imm >> 12) & 32'hFF) << 5);
                m = 25'h1FFFFE0;
            end
            default: ok = 1'b0;
        endcase
        e.err     = !ok;
        e.field   = ok ? f[24:0] : 25'h0;
        e.mask    = ok ? m : 25'h0;
        e.chk_lat = 1'b0;
        e.acc     = 0;
        return e;
    endfunction

    // Called at a falling edge; returns at a falling edge with in_valid low.
    task automatic send(input logic [31:0] imm, input logic [2:0] src, input logic lat);
        exp_t e;
        in_valid  = 1'b1;
        in_imm    = imm;
        in_immsrc = src;
        for (int t = 0; t < 200; t++) begin
            #4;
            if (in_ready) begin
                e = model(imm, src);
                e.chk_lat = lat;
                e.acc = cyc + 1;
                sb.push_back(e);
                @(negedge clk);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        checks = checks + 1;
        failures = failures + 1;
        $display("FAIL accept_timeout imm=%h src=%0d", imm, src);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                @(negedge clk);
                return;
            end
        end
        checks = checks + 1;
        failures = failures + 1;
        $display("FAIL drain_timeout actual=%0d required=0 entries", sb.size());
    endtask

    function automatic logic [31:0] rand_imm();
        int bvals [12] = '{2047, -2048, 2048, -2049, 4094, -4096, 4096, 4095,
                           1048574, -1048576, 1048576, 32'hFFFFF000};
        case ($urandom % 5)
            0: return 32'($urandom_range(0, 8191)) - 32'd4096;
            1: return $urandom;
            2: return $urandom & 32'hFFFFF000;
            3: return 32'($urandom_range(0, 4194303)) - 32'd2097152;
            default: return bvals[$urandom % 12];
        endcase
    endfunction

    // Monitor: acts 2 time units after each falling edge, after the driver.
    initial begin : monitor
        exp_t       e;
        logic       head_seen;
        int         mcnt;
        head_seen = 1'b0;
        mcnt = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                out_ready = 1'b1;
                head_seen = 1'b0;
                mcnt = 0;
            end else begin
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        checks = checks + 1;
                        failures = failures + 1;
                        $display("FAIL spurious_output actual=out_valid required=idle field=%h", out_field);
                    end else begin
                        e = sb[0];
                        chk("field", 32'(out_field), 32'(e.field));
                        chk("mask", 32'(out_mask), 32'(e.mask));
                        chk("err", 32'(out_err), 32'(e.err));
                        if (!head_seen && e.chk_lat) chk("latency", cyc, e.acc + 1);
                        head_seen = 1'b1;
                    end
                end
                out_ready = stall ? 1'b0 : (rand_rdy ? (($urandom % 4) != 0) : 1'b1);
                #1;
                chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
                chk("err_cnt", 32'(err_cnt), mcnt);
                if (out_valid && out_ready && sb.size() != 0) begin
                    e = sb.pop_front();
                    $display("RSP field=%h mask=%h err=%0d err_cnt=%0d", out_field, out_mask, out_err, err_cnt);
                    head_seen = 1'b0;
                    if (e.err && mcnt < (1 << CNT_W) - 1) mcnt = mcnt + 1;
                end
            end
        end
    end

    initial begin : driver
        logic [31:0] d_imm [8]  = '{32'h2, 32'h5, 32'h800, 32'h1000, 32'hFFFFFFFE,
                                   32'h800, 32'h3, 32'h0};
        logic [2:0]  d_src [8]  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd2, 3'd5};
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_field", 32'(out_field), 0);
        chk("rst_mask", 32'(out_mask), 0);
        chk("rst_err", 32'(out_err), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            send(d_imm[i], d_src[i], 1'b1);
            wait_drain();
        end
        chk("err_cnt_after_3", 32'(err_cnt), 3);

        fork
            begin
                repeat (3) @(negedge clk);
                stall = 1'b1;
                repeat (3) @(negedge clk);
                stall = 1'b0;
            end
            begin
                for (int i = 0; i < 8; i++) send(32'(i * 4) - 32'd12, 3'(i % 5), 1'b0);
            end
        join
        wait_drain();

        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(rand_imm(), ($urandom % 10 == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4)), 1'b0);
            if ($urandom % 4 == 0) @(negedge clk);
        end
        wait_drain();
        rand_rdy = 1'b0;

        send(32'h0, 3'd6, 1'b0);
        send(32'h10, 3'd0, 1'b0);
        rst = 1'b1;
        sb.delete();
        #1;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_err_cnt", 32'(err_cnt), 0);
        chk("midrst_field", 32'(out_field), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(32'hFFFFF800, 3'd1, 1'b1);
        wait_drain();
        send(32'h00ABC000, 3'd3, 1'b1);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
